// File: rtl/pic_core_pkg.sv
// Shared constants and types for the PIC16F1826 core front end.
package pic_core_pkg;

  localparam int              PC_WIDTH     = 11;
  localparam int              INSTR_WIDTH  = 14;
  localparam int              STACK_DEPTH  = 16;
  localparam logic [10:0]     RESET_VECTOR = 11'h000;
  localparam logic [13:0]     NOP_WORD     = 14'h0000;

  // Resolved fetch action for one clock, already priority-ordered.
  typedef enum logic [2:0] {
    FETCH_SEQ,
    FETCH_RET,
    FETCH_CALL,
    FETCH_JUMP,
    FETCH_SKIP,
    FETCH_HOLD
  } fetch_op_e;

endpackage

// File: rtl/pic_return_stack.sv
// Circular hardware return stack: a full push overwrites the oldest entry,
// an empty pop leaves the count at zero; both raise sticky flags.
module pic_return_stack #(
  parameter int                W            = 11,
  parameter int                DEPTH        = 16,
  parameter logic [W-1:0]      RESET_VECTOR = '0
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         i_push,
  input  logic         i_pop,
  input  logic [W-1:0] i_push_data,
  output logic [W-1:0] o_top,
  output logic         o_ovf,
  output logic         o_unf
);
  import pic_core_pkg::*;

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = $clog2(DEPTH + 1);

  logic [W-1:0]     r_mem [DEPTH];
  logic [PTR_W-1:0] r_ptr;
  logic [CNT_W-1:0] r_count;
  logic             r_ovf;
  logic             r_unf;
  logic [PTR_W-1:0] w_top_idx;
  logic             w_full;
  logic             w_empty;

  // r_ptr names the next free slot; once full it also names the oldest entry.
  assign w_top_idx = r_ptr - PTR_W'(1);
  assign w_full    = (r_count == CNT_W'(DEPTH));
  assign w_empty   = (r_count == '0);
  assign o_top     = w_empty ? RESET_VECTOR : r_mem[w_top_idx];
  assign o_ovf     = r_ovf;
  assign o_unf     = r_unf;

  always_ff @(posedge clk) begin
    if (i_push) begin
      r_mem[r_ptr] <= i_push_data;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_ptr   <= '0;
      r_count <= '0;
      r_ovf   <= 1'b0;
      r_unf   <= 1'b0;
    end else if (i_push) begin
      r_ptr <= r_ptr + PTR_W'(1);
      if (w_full) begin
        r_ovf <= 1'b1;
      end else begin
        r_count <= r_count + CNT_W'(1);
      end
    end else if (i_pop) begin
      if (w_empty) begin
        r_unf <= 1'b1;
      end else begin
        r_ptr   <= w_top_idx;
        r_count <= r_count - CNT_W'(1);
      end
    end
  end

endmodule

// File: rtl/pic_fetch_unit.sv
// Fetch stage: program counter, ROM addressing, instruction register and
// redirect handling (GOTO/CALL/RETURN/skip) with a one-bubble penalty.
module pic_fetch_unit #(
  parameter int                       PC_WIDTH     = pic_core_pkg::PC_WIDTH,
  parameter int                       INSTR_WIDTH  = pic_core_pkg::INSTR_WIDTH,
  parameter int                       STACK_DEPTH  = pic_core_pkg::STACK_DEPTH,
  parameter logic [PC_WIDTH-1:0]      RESET_VECTOR = pic_core_pkg::RESET_VECTOR
) (
  input  logic                   clk,
  input  logic                   rst,
  output logic [PC_WIDTH-1:0]    rom_addr,
  input  logic [INSTR_WIDTH-1:0] rom_data,
  output logic [INSTR_WIDTH-1:0] ir,
  output logic                   ir_valid,
  output logic [PC_WIDTH-1:0]    ir_pc,
  input  logic                   stall,
  input  logic                   jump_en,
  input  logic                   call_en,
  input  logic                   ret_en,
  input  logic                   skip_en,
  input  logic [PC_WIDTH-1:0]    jump_addr,
  output logic                   stk_ovf,
  output logic                   stk_unf
);
  import pic_core_pkg::*;

  logic [PC_WIDTH-1:0]    r_pc;
  logic [PC_WIDTH-1:0]    r_ir_pc;
  logic [INSTR_WIDTH-1:0] r_ir;
  logic                   r_ir_valid;

  logic [PC_WIDTH-1:0]    w_pc_next;
  logic [PC_WIDTH-1:0]    w_ir_pc_next;
  logic [INSTR_WIDTH-1:0] w_ir_next;
  logic                   w_ir_valid_next;
  logic [PC_WIDTH-1:0]    w_pc_inc;
  logic [PC_WIDTH-1:0]    w_stk_top;
  logic                   w_push;
  logic                   w_pop;
  fetch_op_e              w_op;

  assign w_pc_inc = r_pc + PC_WIDTH'(1);
  assign rom_addr = r_pc;
  assign ir       = r_ir;
  assign ir_valid = r_ir_valid;
  assign ir_pc    = r_ir_pc;

  always_comb begin
    if (stall)        w_op = FETCH_HOLD;
    else if (ret_en)  w_op = FETCH_RET;
    else if (call_en) w_op = FETCH_CALL;
    else if (jump_en) w_op = FETCH_JUMP;
    else if (skip_en) w_op = FETCH_SKIP;
    else              w_op = FETCH_SEQ;
  end

  // Every non-stalled cycle retires the slot at r_pc; redirects turn it into a bubble.
  always_comb begin
    w_pc_next       = r_pc;
    w_ir_next       = r_ir;
    w_ir_valid_next = r_ir_valid;
    w_ir_pc_next    = r_ir_pc;
    w_push          = 1'b0;
    w_pop           = 1'b0;
    if (w_op != FETCH_HOLD) begin
      w_ir_pc_next    = r_pc;
      w_ir_next       = INSTR_WIDTH'(NOP_WORD);
      w_ir_valid_next = 1'b0;
    end
    case (w_op)
      FETCH_SEQ: begin
        w_pc_next       = w_pc_inc;
        w_ir_next       = rom_data;
        w_ir_valid_next = 1'b1;
      end
      FETCH_RET: begin
        w_pc_next = w_stk_top;
        w_pop     = 1'b1;
      end
      FETCH_CALL: begin
        w_pc_next = jump_addr;
        w_push    = 1'b1;
      end
      FETCH_JUMP: w_pc_next = jump_addr;
      FETCH_SKIP: w_pc_next = w_pc_inc;
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_pc       <= RESET_VECTOR;
      r_ir       <= INSTR_WIDTH'(NOP_WORD);
      r_ir_valid <= 1'b0;
      r_ir_pc    <= RESET_VECTOR;
    end else begin
      r_pc       <= w_pc_next;
      r_ir       <= w_ir_next;
      r_ir_valid <= w_ir_valid_next;
      r_ir_pc    <= w_ir_pc_next;
    end
  end

  pic_return_stack #(
    .W            (PC_WIDTH),
    .DEPTH        (STACK_DEPTH),
    .RESET_VECTOR (RESET_VECTOR)
  ) u_stack (
    .clk         (clk),
    .rst         (rst),
    .i_push      (w_push),
    .i_pop       (w_pop),
    .i_push_data (r_pc),
    .o_top       (w_stk_top),
    .o_ovf       (stk_ovf),
    .o_unf       (stk_unf)
  );

endmodule

// File: tb/tb_pic_fetch_unit.sv
// Directed plus randomized bench for pic_fetch_unit against a queue-based fetch model.
module tb_pic_fetch_unit;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [10:0] rom_addr;
  logic [13:0] rom_data;
  logic [13:0] ir;
  logic        ir_valid;
  logic [10:0] ir_pc;
  logic        stall = 1'b0, jump_en = 1'b0, call_en = 1'b0, ret_en = 1'b0, skip_en = 1'b0;
  logic [10:0] jump_addr = '0;
  logic        stk_ovf, stk_unf;

  logic [13:0] rom_mem [2048];
  assign rom_data = rom_mem[rom_addr];

  int n_checks = 0;
  int n_errors = 0;

  // Reference model: architectural PC, IR and an unbounded queue trimmed to 16.
  int m_pc, m_ir, m_valid, m_ir_pc, m_ovf, m_unf;
  int m_stk[$];

  always #5 clk = ~clk;

  pic_fetch_unit dut (
    .clk(clk), .rst(rst), .rom_addr(rom_addr), .rom_data(rom_data),
    .ir(ir), .ir_valid(ir_valid), .ir_pc(ir_pc), .stall(stall),
    .jump_en(jump_en), .call_en(call_en), .ret_en(ret_en), .skip_en(skip_en),
    .jump_addr(jump_addr), .stk_ovf(stk_ovf), .stk_unf(stk_unf)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic compare_all();
    chk("rom_addr", 32'(rom_addr), 32'(m_pc));
    chk("ir", 32'(ir), 32'(m_ir));
    chk("ir_valid", 32'(ir_valid), 32'(m_valid));
    chk("ir_pc", 32'(ir_pc), 32'(m_ir_pc));
    chk("stk_ovf", 32'(stk_ovf), 32'(m_ovf));
    chk("stk_unf", 32'(stk_unf), 32'(m_unf));
  endtask

  task automatic model_edge(input bit s, input bit j, input bit c, input bit r,
                            input bit k, input int a);
    if (s) return;
    m_ir_pc = m_pc;
    if (!r && !c && !j && !k) begin
      m_ir    = int'(rom_mem[m_pc]);
      m_valid = 1;
      m_pc    = (m_pc + 1) % 2048;
      return;
    end
    m_ir    = 0;
    m_valid = 0;
    if (r) begin
      if (m_stk.size() == 0) begin
        m_pc  = 0;
        m_unf = 1;
      end else begin
        m_pc = m_stk.pop_back();
      end
    end else if (c) begin
      m_stk.push_back(m_pc);
      if (m_stk.size() > 16) begin
        void'(m_stk.pop_front());
        m_ovf = 1;
      end
      m_pc = a;
    end else if (j) begin
      m_pc = a;
    end else begin
      m_pc = (m_pc + 1) % 2048;
    end
  endtask

  task automatic step(input bit s, input bit j, input bit c, input bit r,
                      input bit k, input int a);
    stall = s; jump_en = j; call_en = c; ret_en = r; skip_en = k;
    jump_addr = 11'(a);
    @(posedge clk);
    model_edge(s, j, c, r, k, a);
    #1;
    $display("step stall=%0b j=%0b c=%0b r=%0b k=%0b a=%03h -> pc=%03h ir=%04h v=%0b ir_pc=%03h ovf=%0b unf=%0b",
             s, j, c, r, k, a, rom_addr, ir, ir_valid, ir_pc, stk_ovf, stk_unf);
    compare_all();
  endtask

  task automatic plain(input int n);
    for (int i = 0; i < n; i++) step(0, 0, 0, 0, 0, 0);
  endtask

  // Asserts reset mid-cycle with whatever controls are pending, then releases it.
  task automatic do_reset();
    rst = 1'b1;
    #1;
    m_pc = 0; m_ir = 0; m_valid = 0; m_ir_pc = 0; m_ovf = 0; m_unf = 0;
    m_stk.delete();
    $display("reset -> pc=%03h ir=%04h v=%0b ir_pc=%03h ovf=%0b unf=%0b",
             rom_addr, ir, ir_valid, ir_pc, stk_ovf, stk_unf);
    compare_all();
    @(negedge clk);
    rst = 1'b0;
    stall = 0; jump_en = 0; call_en = 0; ret_en = 0; skip_en = 0;
  endtask

  initial begin
    for (int i = 0; i < 2048; i++) rom_mem[i] = 14'($urandom);

    // Reset state and straight-line fetch
    @(posedge clk); #1;
    do_reset();
    chk("rst_rom_addr", 32'(rom_addr), 32'h000);
    chk("rst_ir_valid", 32'(ir_valid), 32'h0);
    for (int i = 0; i < 4; i++) begin
      step(0, 0, 0, 0, 0, 0);
      chk("seq_rom_addr", 32'(rom_addr), 32'(i + 1));
      chk("seq_ir_pc", 32'(ir_pc), 32'(i));
      chk("seq_valid", 32'(ir_valid), 32'h1);
    end

    // GOTO from 0x008 to 0x012
    plain(4);
    chk("pre_jump_pc", 32'(rom_addr), 32'h008);
    step(0, 1, 0, 0, 0, 'h012);
    chk("jump_ir", 32'(ir), 32'h0);
    chk("jump_valid", 32'(ir_valid), 32'h0);
    chk("jump_pc", 32'(rom_addr), 32'h012);
    step(0, 0, 0, 0, 0, 0);
    chk("jump_target_ir", 32'(ir), 32'(rom_mem[12'h012]));
    chk("jump_target_ir_pc", 32'(ir_pc), 32'h012);

    // CALL at 0x005 to 0x100, then RETURN
    do_reset();
    plain(5);
    step(0, 0, 1, 0, 0, 'h100);
    chk("call_pc", 32'(rom_addr), 32'h100);
    plain(3);
    step(0, 0, 0, 1, 0, 0);
    chk("ret_pc", 32'(rom_addr), 32'h005);
    chk("ret_valid", 32'(ir_valid), 32'h0);
    step(0, 0, 0, 0, 0, 0);
    chk("ret_ir_pc", 32'(ir_pc), 32'h005);

    // Overflow then underflow of the return stack
    do_reset();
    for (int i = 0; i < 17; i++) begin
      step(0, 0, 1, 0, 0, 'h200 + i);
      if (i == 15) chk("ovf_before_17", 32'(stk_ovf), 32'h0);
    end
    chk("ovf_after_17", 32'(stk_ovf), 32'h1);
    for (int k = 0; k < 16; k++) begin
      step(0, 0, 0, 1, 0, 0);
      chk("ret_order", 32'(rom_addr), 32'('h200 + 15 - k));
    end
    chk("unf_before_17th", 32'(stk_unf), 32'h0);
    step(0, 0, 0, 1, 0, 0);
    chk("unf_pc", 32'(rom_addr), 32'h000);
    chk("unf_flag", 32'(stk_unf), 32'h1);

    // Stall with jump pending, then reset during stall
    step(0, 0, 0, 0, 0, 0);
    step(1, 1, 0, 0, 0, 'h055);
    step(1, 1, 0, 0, 0, 'h055);
    chk("stall_pc", 32'(rom_addr), 32'h001);
    chk("stall_ir_pc", 32'(ir_pc), 32'h000);
    chk("stall_unf", 32'(stk_unf), 32'h1);
    stall = 1; jump_en = 1; jump_addr = 11'h055;
    #2;
    do_reset();
    chk("rst_stall_pc", 32'(rom_addr), 32'h000);
    chk("rst_stall_ovf", 32'(stk_ovf), 32'h0);
    chk("rst_stall_unf", 32'(stk_unf), 32'h0);

    // PC wrap and skip
    step(0, 1, 0, 0, 0, 'h7FF);
    step(0, 0, 0, 0, 0, 0);
    chk("wrap_pc", 32'(rom_addr), 32'h000);
    chk("wrap_ir_pc", 32'(ir_pc), 32'h7FF);
    do_reset();
    plain(10);
    step(0, 0, 0, 0, 1, 0);
    chk("skip_ir", 32'(ir), 32'h0);
    chk("skip_valid", 32'(ir_valid), 32'h0);
    chk("skip_pc", 32'(rom_addr), 32'h00B);
    chk("skip_ir_pc", 32'(ir_pc), 32'h00A);

    // Randomized traffic against the model
    for (int n = 0; n < 3000; n++) begin
      int sel;
      bit s, j, c, r, k;
      sel = int'($urandom_range(0, 99));
      if (sel == 0) begin
        do_reset();
      end else begin
        s = ($urandom_range(0, 99) < 15);
        j = (sel >= 1 && sel < 8);
        c = (sel >= 6 && sel < 16);
        r = (sel >= 14 && sel < 24);
        k = (sel >= 22 && sel < 28) || ($urandom_range(0, 19) == 0);
        step(s, j, c, r, k, int'($urandom_range(0, 2047)));
      end
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
